// File: rtl/tone_synth_pkg.sv
// Shared constants, state type and pitch helper for the tone synthesiser.
// Latency: none (elaboration-time constants only).
// Backpressure: not applicable.
package tone_synth_pkg;

  // Base-octave note frequencies in Hz, one per key, lowest key first.
  localparam int unsigned NOTE_HZ_BASE [0:15] = '{
    233, 247, 262, 277, 294, 311, 330, 349,
    370, 392, 415, 440, 466, 494, 523, 554
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TONE   = 2'd1,
    PAUSED = 2'd2
  } state_e;

  // Half-period in clock cycles for a square wave of frequency hz.
  function automatic int unsigned half_of(input int unsigned clk_hz, input int unsigned hz);
    return clk_hz / (2 * hz);
  endfunction

endpackage

// File: rtl/tone_edge_det.sv
// Rising-edge detector: one-cycle pulse when the level input goes 0 -> 1.
// Latency: combinational pulse in the same cycle as the rising level.
// Backpressure: none; a held level produces a single pulse.
module tone_edge_det (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic pulse_o
);

  logic prev_q;

  // Remember last cycle's level so the rise can be seen.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) prev_q <= 1'b0;
    else          prev_q <= d_i;
  end

  assign pulse_o = d_i & ~prev_q;

endmodule

// File: rtl/tone_synth.sv
// Square-wave tone generator: priority key select, octave shift, glitch-free pitch reload.
// Latency: tone starts one cycle after key+run; pitch changes land only on half-period boundaries.
// Backpressure: none; buttons are edge-detected so a held press acts once.
// Build option: define TONE_SYNTH_SUSTAIN_EN to keep sounding SUSTAIN_CYC cycles after key release.
import tone_synth_pkg::*;

module tone_synth #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int          NUM_KEYS    = 16,
  parameter int          OCT_MAX     = 7,
  parameter int          OCT_RST     = 2,
  parameter int          CNT_W       = 24,
  parameter int          SUSTAIN_CYC = 5_000_000
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [NUM_KEYS-1:0] key_i,
  input  logic                pause_btn_i,
  input  logic                oct_dn_i,
  input  logic                oct_up_i,
  output logic                tone_out_o,
  output logic                active_o,
  output logic                run_en_o,
  output logic [2:0]          oct_o,
  output logic [CNT_W-1:0]    half_period_o
);

  // ---------------------------------------------------------------
  // Button edge detection
  // ---------------------------------------------------------------
  logic pause_p, dn_p, up_p;

  tone_edge_det u_pause_det (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(pause_btn_i), .pulse_o(pause_p));
  tone_edge_det u_dn_det    (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(oct_dn_i),    .pulse_o(dn_p));
  tone_edge_det u_up_det    (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(oct_up_i),    .pulse_o(up_p));

  // ---------------------------------------------------------------
  // Run flag and octave register
  // ---------------------------------------------------------------
  logic       run_en_q, run_en_d;
  logic [2:0] oct_q, oct_d;

  // Pause toggles run; octave steps saturate, simultaneous up+down cancel.
  always_comb begin
    run_en_d = run_en_q ^ pause_p;
    oct_d    = oct_q;
    if (up_p && !dn_p && (oct_q < 3'(OCT_MAX)))
      oct_d = oct_q + 3'd1;
    else if (dn_p && !up_p && (oct_q != 3'd0))
      oct_d = oct_q - 3'd1;
  end

  // Control registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_en_q <= 1'b0;
      oct_q    <= 3'(OCT_RST);
    end else begin
      run_en_q <= run_en_d;
      oct_q    <= oct_d;
    end
  end

  // ---------------------------------------------------------------
  // Key priority encoder (lowest index wins) and pitch table
  // ---------------------------------------------------------------
  logic             key_vld;
  logic [3:0]       key_idx;
  logic [3:0]       sel_idx;
  logic             snd_vld;
  logic [CNT_W-1:0] base_half [NUM_KEYS];
  logic [CNT_W-1:0] shifted;
  logic [CNT_W-1:0] pitch_h;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_base
    assign base_half[g] = CNT_W'(half_of(CLK_HZ, NOTE_HZ_BASE[g]));
  end

  // Scan from the top down so the lowest asserted key is the last writer.
  always_comb begin
    key_vld = 1'b0;
    key_idx = 4'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_i[i]) begin
        key_vld = 1'b1;
        key_idx = 4'(i);
      end
    end
  end

  // Octave shift with a floor of 2 so the counter always has room to count.
  always_comb begin
    shifted = base_half[sel_idx] >> oct_q;
    pitch_h = (shifted < CNT_W'(2)) ? CNT_W'(2) : shifted;
  end

  // ---------------------------------------------------------------
  // Tone FSM and half-period datapath
  // ---------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             tone_q, tone_d;
  logic             at_bound;

  assign at_bound = (cnt_q == half_q - CNT_W'(1));

`ifdef TONE_SYNTH_SUSTAIN_EN
  // Sustain: after release, keep the last key sounding until the countdown expires.
  logic             sus_on_q, sus_on_d;
  logic [CNT_W-1:0] sus_cnt_q, sus_cnt_d;
  logic [3:0]       last_idx_q, last_idx_d;

  assign sel_idx = key_vld ? key_idx : last_idx_q;
  assign snd_vld = key_vld | ((state_q == TONE) & (~sus_on_q | (sus_cnt_q != '0)));

  // Arm on release, count only while running, cancel on a new press or on stopping.
  always_comb begin
    sus_on_d   = sus_on_q;
    sus_cnt_d  = sus_cnt_q;
    last_idx_d = key_vld ? key_idx : last_idx_q;
    if (state_q == TONE && run_en_q) begin
      if (key_vld) begin
        sus_on_d = 1'b0;
      end else if (!sus_on_q) begin
        sus_on_d  = 1'b1;
        sus_cnt_d = CNT_W'(SUSTAIN_CYC);
      end else if (sus_cnt_q != '0) begin
        sus_cnt_d = sus_cnt_q - CNT_W'(1);
      end
    end
    if (state_d == IDLE) sus_on_d = 1'b0;
  end

  // Sustain registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sus_on_q   <= 1'b0;
      sus_cnt_q  <= '0;
      last_idx_q <= 4'd0;
    end else begin
      sus_on_q   <= sus_on_d;
      sus_cnt_q  <= sus_cnt_d;
      last_idx_q <= last_idx_d;
    end
  end
`else
  logic unused_sustain;

  assign sel_idx        = key_idx;
  assign snd_vld        = key_vld;
  assign unused_sustain = ^SUSTAIN_CYC;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: start on key+run, freeze on pause, stop only on a boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (key_vld && run_en_q) state_d = TONE;
      TONE: begin
        if (!run_en_q)                state_d = PAUSED;
        else if (at_bound && !snd_vld) state_d = IDLE;
      end
      PAUSED:  if (run_en_q) state_d = TONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: count, toggle and reload the pitch only at the boundary.
  always_comb begin
    cnt_d  = cnt_q;
    half_d = half_q;
    tone_d = tone_q;
    case (state_q)
      IDLE: begin
        if (key_vld && run_en_q) begin
          cnt_d  = '0;
          half_d = pitch_h;
          tone_d = 1'b1;
        end
      end
      TONE: begin
        if (run_en_q) begin
          if (at_bound) begin
            cnt_d = '0;
            if (snd_vld) begin
              tone_d = ~tone_q;
              half_d = pitch_h;
            end else begin
              tone_d = 1'b0;
              half_d = '0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      half_q <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      tone_q <= tone_d;
    end
  end

  assign tone_out_o    = tone_q;
  assign active_o      = (state_q == TONE);
  assign run_en_o      = run_en_q;
  assign oct_o         = oct_q;
  assign half_period_o = half_q;

endmodule
